// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshakes of the multi-cycle sequencer: the instruction
// fetch port and the data access port. The sequencer is the master.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I DataPath. Fetches through a req/ack
// handshake into an instruction register, steps FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath control strobe, the data-memory handshake and
// the retired-instruction counter. Illegal opcodes park it in TRAP.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master mem,
    output logic [31:0]       instr,
    input  logic [6:0]        op_code,
    input  logic [2:0]        f3,
    input  logic              f7,
    output logic              branch,
    output logic [1:0]        jump,
    output logic [1:0]        dato_s,
    output logic              reg_w,
    output logic              alu_s,
    output logic [2:0]        alu_op,
    output logic              trap,
    output logic [31:0]       instret,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_R,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC,
        CL_ILLEGAL
    } iclass_t;

    localparam logic [1:0] JMP_HOLD = 2'b00;
    localparam logic [1:0] JMP_SEQ  = 2'b01;
    localparam logic [1:0] JMP_JAL  = 2'b10;
    localparam logic [1:0] JMP_JALR = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_FUNCT  = 3'b010;
    localparam logic [2:0] ALU_BRANCH = 3'b011;

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    logic [31:0] instret_q;
    iclass_t     iclass;

    // Class-dependent ALU setup, shared by EXEC, MEM and WB.
    logic        cls_alu_s;
    logic [2:0]  cls_alu_op;

    // Ungated strobes; reset masking is applied at the output stage.
    logic        imem_req_c;
    logic        dmem_req_c;
    logic        dmem_we_c;
    logic        branch_c;
    logic        reg_w_c;
    logic        alu_s_c;
    logic        retire_c;
    logic [1:0]  jump_c;
    logic [1:0]  dato_s_c;
    logic [2:0]  alu_op_c;

    // funct3/funct7 only matter to the datapath's own ALU decoder; the
    // sequencer hands over with alu_op=010 and never inspects them.
    logic unused_funct;
    assign unused_funct = ^{f3, f7};

    // Classify the opcode the datapath decodes back from the IR.
    always_comb begin
        case (op_code)
            7'b0110011: iclass = CL_R;
            7'b0010011: iclass = CL_IALU;
            7'b0000011: iclass = CL_LOAD;
            7'b0100011: iclass = CL_STORE;
            7'b1100011: iclass = CL_BRANCH;
            7'b1101111: iclass = CL_JAL;
            7'b1100111: iclass = CL_JALR;
            7'b0110111: iclass = CL_LUI;
            7'b0010111: iclass = CL_AUIPC;
            default:    iclass = CL_ILLEGAL;
        endcase
    end

    // ALU operand/operation per instruction class.
    always_comb begin
        cls_alu_s  = 1'b0;
        cls_alu_op = ALU_ADD;
        case (iclass)
            CL_R:               begin cls_alu_s = 1'b0; cls_alu_op = ALU_FUNCT;  end
            CL_IALU:            begin cls_alu_s = 1'b1; cls_alu_op = ALU_FUNCT;  end
            CL_LOAD, CL_STORE:  begin cls_alu_s = 1'b1; cls_alu_op = ALU_ADD;    end
            CL_BRANCH:          begin cls_alu_s = 1'b0; cls_alu_op = ALU_BRANCH; end
            default:            begin cls_alu_s = 1'b0; cls_alu_op = ALU_ADD;    end
        endcase
    end

    // Next-state and strobe decode for the sequencer FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        branch_c   = 1'b0;
        reg_w_c    = 1'b0;
        alu_s_c    = 1'b0;
        alu_op_c   = ALU_ADD;
        jump_c     = JMP_HOLD;
        dato_s_c   = WB_ALU;
        retire_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ack) state_d = S_DECODE;
            end

            S_DECODE: begin
                state_d = (iclass == CL_ILLEGAL) ? S_TRAP : S_EXEC;
            end

            S_EXEC: begin
                alu_s_c  = cls_alu_s;
                alu_op_c = cls_alu_op;
                case (iclass)
                    CL_BRANCH: begin
                        branch_c = 1'b1;
                        jump_c   = JMP_SEQ;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end

            S_MEM: begin
                alu_s_c    = cls_alu_s;
                alu_op_c   = cls_alu_op;
                dmem_req_c = 1'b1;
                dmem_we_c  = (iclass == CL_STORE);
                if (mem.dmem_ack) begin
                    if (iclass == CL_STORE) begin
                        jump_c   = JMP_SEQ;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                // ALU setup stays as in EXEC so the write-back value is the
                // ALU result; AUIPC falls through to add (PC + imm).
                alu_s_c  = cls_alu_s;
                alu_op_c = cls_alu_op;
                reg_w_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
                jump_c   = JMP_SEQ;
                case (iclass)
                    CL_LOAD: dato_s_c = WB_MEM;
                    CL_JAL:  begin dato_s_c = WB_LINK; jump_c = JMP_JAL;  end
                    CL_JALR: begin dato_s_c = WB_LINK; jump_c = JMP_JALR; end
                    CL_LUI:  dato_s_c = WB_IMM;
                    default: dato_s_c = WB_ALU;
                endcase
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                // Unused encodings recover into a fresh fetch.
                state_d = S_FETCH;
            end
        endcase
    end

    // State register, instruction register and retired-instruction counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // values from before this edge, independent of statement order.
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= RESET_IR;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && mem.imem_ack) ir_q <= mem.imem_rdata;
            if (retire_c) instret_q <= instret_q + 32'd1;
        end
    end

    // Reset masks every output so an aborted access or write never leaks out.
    always_comb begin
        if (rst) begin
            mem.imem_req = 1'b0;
            mem.dmem_req = 1'b0;
            mem.dmem_we  = 1'b0;
            instr        = '0;
            branch       = 1'b0;
            jump         = JMP_HOLD;
            dato_s       = WB_ALU;
            reg_w        = 1'b0;
            alu_s        = 1'b0;
            alu_op       = ALU_ADD;
            trap         = 1'b0;
            instret      = '0;
            state        = 3'd0;
        end else begin
            mem.imem_req = imem_req_c;
            mem.dmem_req = dmem_req_c;
            mem.dmem_we  = dmem_we_c;
            instr        = ir_q;
            branch       = branch_c;
            jump         = jump_c;
            dato_s       = dato_s_c;
            reg_w        = reg_w_c;
            alu_s        = alu_s_c;
            alu_op       = alu_op_c;
            trap         = (state_q == S_TRAP);
            instret      = instret_q;
            state        = state_q;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised scoreboard bench for multicycle_ctrl. The stimulus side acts as
// instruction and data memory and pushes the expected retirement of each
// instruction; a negedge monitor pops and compares at every retirement.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    logic [31:0] instr;
    logic [6:0]  op_code;
    logic [2:0]  f3;
    logic        f7;
    logic        branch;
    logic [1:0]  jump;
    logic [1:0]  dato_s;
    logic        reg_w;
    logic        alu_s;
    logic [2:0]  alu_op;
    logic        trap;
    logic [31:0] instret;
    logic [2:0]  state;

    // The datapath decodes these straight from the IR.
    assign op_code = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[30];

    multicycle_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (bus),
        .instr   (instr),
        .op_code (op_code),
        .f3      (f3),
        .f7      (f7),
        .branch  (branch),
        .jump    (jump),
        .dato_s  (dato_s),
        .reg_w   (reg_w),
        .alu_s   (alu_s),
        .alu_op  (alu_op),
        .trap    (trap),
        .instret (instret),
        .state   (state)
    );

    localparam logic [6:0] LEGAL_OPS [9] = '{
        7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111
    };

    typedef struct {
        bit          legal;
        logic [31:0] word;
        logic [31:0] instret;
        int          cycles;
        logic [1:0]  jump;
        logic [1:0]  dato_s;
        logic        reg_w;
        logic        branch;
        bit          is_mem;
        bit          is_store;
        bit          is_auipc;
        bit          chk_alu;
        logic        alu_s;
        logic [2:0]  alu_op;
    } exp_t;

    exp_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] n_ret = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference behaviour of one instruction: what it must show when it retires.
    function automatic exp_t model(input logic [31:0] w, input int iw, input int dw,
                                   input logic [31:0] cnt);
        exp_t e;
        e.legal = 1'b1;  e.word = w;      e.instret = cnt;  e.cycles = 4 + iw;
        e.jump = 2'b01;  e.dato_s = 2'b00; e.reg_w = 1'b1;  e.branch = 1'b0;
        e.is_mem = 1'b0; e.is_store = 1'b0; e.is_auipc = 1'b0;
        e.chk_alu = 1'b0; e.alu_s = 1'b0; e.alu_op = 3'b000;
        case (w[6:0])
            7'b0110011: begin e.chk_alu = 1; e.alu_s = 0; e.alu_op = 3'b010; end
            7'b0010011: begin e.chk_alu = 1; e.alu_s = 1; e.alu_op = 3'b010; end
            7'b0000011: begin
                e.chk_alu = 1; e.alu_s = 1; e.alu_op = 3'b000;
                e.is_mem = 1; e.dato_s = 2'b01; e.cycles = 5 + iw + dw;
            end
            7'b0100011: begin
                e.chk_alu = 1; e.alu_s = 1; e.alu_op = 3'b000;
                e.is_mem = 1; e.is_store = 1; e.reg_w = 0; e.cycles = 4 + iw + dw;
            end
            7'b1100011: begin
                e.chk_alu = 1; e.alu_s = 0; e.alu_op = 3'b011;
                e.branch = 1; e.reg_w = 0; e.cycles = 3 + iw;
            end
            7'b1101111: begin e.dato_s = 2'b10; e.jump = 2'b10; end
            7'b1100111: begin e.dato_s = 2'b10; e.jump = 2'b11; end
            7'b0110111: e.dato_s = 2'b11;
            7'b0010111: e.is_auipc = 1;
            default:    e.legal = 1'b0;
        endcase
        return e;
    endfunction

    // Instruction memory: waits for the request (scattering ignored acks while
    // it is low), holds off iw cycles, then returns the word.
    task automatic fetch(input logic [31:0] word, input int iw, input exp_t e);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 40) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            bus.dmem_ack   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (bus.imem_req !== 1'b1) begin
            check("imem_req_timeout", bus.imem_req, 1);
            return;
        end
        repeat (iw) begin @(posedge clk); #1; end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        if (e.legal) exp_q.push_back(e);
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
    endtask

    // Data memory: same pattern on the data port.
    task automatic data_access(input int dw);
        int n = 0;
        while (bus.dmem_req !== 1'b1 && n < 10) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            bus.dmem_ack   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (bus.dmem_req !== 1'b1) begin
            check("dmem_req_timeout", bus.dmem_req, 1);
            return;
        end
        repeat (dw) begin @(posedge clk); #1; end
        bus.dmem_ack = 1'b1;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
    endtask

    task automatic issue(input logic [31:0] word, input int iw, input int dw);
        exp_t e = model(word, iw, dw, n_ret);
        fetch(word, iw, e);
        if (e.legal) n_ret++;
        if (e.is_mem) data_access(dw);
    endtask

    task automatic random_instr();
        logic [31:0] w = $urandom;
        int iw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        int dw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        w[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
        issue(w, iw, dw);
    endtask

    task automatic do_reset(input int cycles);
        rst          = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        exp_q.delete();
        n_ret = '0;
        repeat (cycles) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("imem_req_after_reset", bus.imem_req, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: reset masking, per-state strobes and retirement comparison.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            cyc = 0;
            check("reset_outputs_zero",
                  {bus.imem_req, bus.dmem_req, bus.dmem_we, instr, branch, jump, dato_s,
                   reg_w, alu_s, alu_op, trap, instret, state}, '0);
        end else begin
            cyc++;
            if (state == 3'd7)
                check("trap_quiet", {trap, bus.imem_req, bus.dmem_req, branch, jump, reg_w},
                      7'b1000000);
            if (jump == 2'b00)
                check("strobe_outside_retire", {reg_w, branch}, 2'b00);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                if (state inside {3'd1, 3'd2, 3'd3, 3'd4})
                    check("ir_stable", instr, e.word);
                if (state == 3'd2 && e.chk_alu)
                    check("exec_alu", {alu_s, alu_op}, {e.alu_s, e.alu_op});
                if (state == 3'd3)
                    check("mem_strobes", {bus.dmem_req, bus.dmem_we, alu_s, alu_op},
                          {1'b1, e.is_store, e.alu_s, e.alu_op});
            end
            if (jump != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", jump, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("retire_jump", jump, e.jump);
                    check("retire_reg_w", reg_w, e.reg_w);
                    check("retire_branch", branch, e.branch);
                    if (e.reg_w) check("retire_dato_s", dato_s, e.dato_s);
                    check("retire_cycles", cyc, e.cycles);
                    check("retire_instret", instret, e.instret);
                    check("retire_dmem", {bus.dmem_req, bus.dmem_we},
                          e.is_store ? 2'b11 : 2'b00);
                    if (e.is_auipc) check("auipc_alu_op", alu_op, 3'b000);
                    cyc = 0;
                end
            end
        end
    end

    initial begin
        #1ms;
        total++;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        exp_t e;
        int   n;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack   = 1'b0;
        @(posedge clk); #1;
        do_reset(3);

        issue(32'h01528B13, 0, 0);   // addi, zero-wait
        issue(32'h0002A303, 0, 2);   // lw, two data wait cycles
        issue(32'h0062A023, 0, 0);   // sw, zero-wait
        issue(32'h00628463, 0, 0);   // beq
        issue(32'h00000317, 1, 0);   // auipc with one fetch wait

        for (int i = 0; i < 150; i++) random_instr();
        drain();

        // Reset in the second wait cycle of a load's data access.
        e = model(32'h0002A303, 0, 0, n_ret);
        fetch(32'h0002A303, 0, e);
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
        check("lw_reached_mem", bus.dmem_req, 1);
        @(posedge clk); #1;
        do_reset(1);

        for (int i = 0; i < 40; i++) random_instr();
        drain();

        // Illegal opcode: sticky trap, no further fetches until reset.
        issue(32'h0000007F, 0, 0);
        repeat (22) begin @(posedge clk); #1; end
        check("trap_sticky", trap, 1);
        check("trap_no_fetch", bus.imem_req, 0);
        do_reset(1);
        check("trap_cleared", trap, 0);
        issue(32'h01528B13, 0, 0);
        issue(32'h00628463, 2, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
